alu_exec_sequencer: RTL and testbench
=====================================

# alu_exec_sequencer

Execution-stage controller for the 16-bit RISC datapath. Accepts one decoded ALU operation (the shared `aluctrl` control struct plus two operands) per valid/ready handshake. Single-cycle operations complete in one cycle; multiply, divide and modulo are sequenced over an iterative shift-add / restoring-divide core. It also owns the architectural compare flags (`flg`: GT, ET) and produces the stall back-pressure the pipeline uses while a long operation is in flight.

## Interface
- `DATA_WIDTH`, 16, operand/result width; iteration count of mul/div/mod equals `DATA_WIDTH`.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  operation accepted when `in_valid & in_ready`.
- `ctrl`  in  aluctrl  decoded operation select.
- `op_a`, `op_b`  in  DATA_WIDTH each  operands.
- `out_valid`  out  1  result/flags valid, held until consumed.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `result`  out  DATA_WIDTH  operation result.
- `flags`  out  flg  architectural compare flags; persistent.
- `div_by_zero`  out  1  qualifies `result` for div/mod with `op_b == 0`.
- `illegal_op`  out  1  qualifies `result` when no `ctrl` bit is set.
- `busy`  out  1  high in MULDIV state (pipeline stall).

## Operation
- States: IDLE, MULDIV, DONE. Reset → IDLE. On reset, `out_valid`, `result`, `flags.GT`, `flags.ET`, `div_by_zero`, `illegal_op` and `busy` are all 0.
- `in_ready = (state==IDLE) & (!out_valid | out_ready)`. Accepting an operation in the same cycle the previous result is consumed is legal.
- `ctrl` select priority when more than one bit is set: Add > Sub > Cmp > Mul > Div > Mod > Lsl > Lsr > Asr > Or > And > Not > Mov. No bit set → `result = 0`, `illegal_op = 1`.
- Single-cycle ops, all modulo 2^DATA_WIDTH:
  - Add: `a + b`. Sub: `a - b`.
  - Lsl/Lsr: logical shift of `a` by `op_b[3:0]`. Asr: arithmetic shift of `a` by `op_b[3:0]`. Upper bits of `op_b` are ignored.
  - Or/And: bitwise `a` with `b`. Not: `~a`. Mov: `b`.
- Cmp: signed compare. GT = `$signed(a) > $signed(b)`, ET = `a == b`. `result = 0`.
- `flags` update only on an accepted Cmp. All other ops leave `flags` unchanged.
- Mul: accept → MULDIV. Runs DATA_WIDTH shift-add iterations. `result` = low DATA_WIDTH bits of the product (sign-agnostic).
- Div/Mod: unsigned restoring divide, DATA_WIDTH iterations. Div returns the quotient; Mod returns the remainder.
- Div/Mod with `op_b == 0`: no iteration. Single-cycle path with `div_by_zero = 1`; Div → `0xFFFF`, Mod → `op_a`.
- MULDIV → DONE when the iteration counter reaches DATA_WIDTH-1. DONE → IDLE when the result is consumed.
- `in_valid` is ignored while not IDLE. `ctrl` and operands are captured at accept; later input changes have no effect.
- `rst` in any state aborts the operation: counter cleared, partial result discarded, outputs forced to reset values next cycle.

## Timing
- Accept at edge N:
  - Single-cycle op or div-by-zero → `out_valid` high after edge N+1 (latency 1).
  - Mul/Div/Mod → `out_valid` high after edge N+DATA_WIDTH+1 (latency 17 at default).
- `busy` is high for exactly DATA_WIDTH cycles per mul/div/mod.
- Under `out_ready = 0`:
  - `result`, `flags`, `div_by_zero` and `illegal_op` hold stable while `out_valid` is high.
  - `in_ready` stays 0 until the result is consumed.
- Peak throughput: one single-cycle op per cycle with `out_ready` held high.

## Structure
- Shared package additions:
  - `DATA_WIDTH` constant.
  - State enum `alu_seq_state_e` {IDLE, MULDIV, DONE}.
  - Existing `aluctrl` and `flg` structs are reused unchanged.
- Sub-module `alu_muldiv_iter` contains the iterative mul/div core:
  - Inputs: start, op select, operands.
  - Outputs: product/quotient/remainder, done pulse.
  - Internals: iteration counter and shift registers.
- The sequencer owns the FSM, the handshake, the single-cycle ops and the flags register.

## Test plan
- Add `0x7FFF + 0x0001`, `out_ready = 1` → `result = 0x8000` one cycle after accept, `flags` unchanged.
- Mul `300 × 300` → `result = 0x5F90` 17 cycles after accept. `busy` high 16 cycles; `in_ready` low throughout.
- Div `100 / 7` → `0x000E`. Mod `100 % 7` → `0x0002`. Div `5 / 0` → `0xFFFF` with `div_by_zero = 1` at latency 1.
- Cmp `0xFFFF` vs `0x0001` → GT = 0, ET = 0. Then Cmp `0x0005` vs `0x0005` → ET = 1, GT = 0. A following Add leaves flags unchanged.
- Back-pressure: `out_ready = 0` for 5 cycles after an Or result → `result` stable, `in_ready = 0`. Releasing `out_ready` with a new op pending → new op accepted in the same cycle.
- Reset mid-divide at iteration 8 → next cycle state IDLE, `out_valid = 0`, `flags = 0`. A subsequent Mov `0x1234` returns `0x1234` at latency 1.

Source files
------------

// File: rtl/alu_exec_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_sequencer_pkg
// Brief    : Shared ALU control/flag types, sequencer state and op decode
// Revision : 1.0
// ============================================================================
package alu_exec_sequencer_pkg;

    localparam int DATA_WIDTH = 16;

    typedef struct packed {
        logic Add;
        logic Sub;
        logic Cmp;
        logic Mul;
        logic Div;
        logic Mod;
        logic Lsl;
        logic Lsr;
        logic Asr;
        logic Or;
        logic And;
        logic Not;
        logic Mov;
    } aluctrl;

    typedef struct packed {
        logic GT;
        logic ET;
    } flg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULDIV = 2'd1,
        DONE   = 2'd2
    } alu_seq_state_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_CMP, OP_MUL, OP_DIV, OP_MOD, OP_LSL,
        OP_LSR, OP_ASR, OP_OR, OP_AND, OP_NOT, OP_MOV, OP_ILLEGAL
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_MOD = 2'd2
    } md_op_e;

    // Resolves multi-hot control words to the single highest-priority op.
    function automatic alu_op_e decode_op(input aluctrl c);
        if (c.Add)      return OP_ADD;
        else if (c.Sub) return OP_SUB;
        else if (c.Cmp) return OP_CMP;
        else if (c.Mul) return OP_MUL;
        else if (c.Div) return OP_DIV;
        else if (c.Mod) return OP_MOD;
        else if (c.Lsl) return OP_LSL;
        else if (c.Lsr) return OP_LSR;
        else if (c.Asr) return OP_ASR;
        else if (c.Or)  return OP_OR;
        else if (c.And) return OP_AND;
        else if (c.Not) return OP_NOT;
        else if (c.Mov) return OP_MOV;
        return OP_ILLEGAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_sequencer_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_iter
// Brief    : Iterative shift-add multiplier and restoring unsigned divider
// Revision : 1.0
// ============================================================================
module alu_muldiv_iter
    import alu_exec_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isMul,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic               r_running;
    logic               r_isMul;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_remSub;

    // Dividend shifts out of the quotient register's MSB as quotient bits shift in.
    assign w_remShift = {r_rem, r_quot[WIDTH-1]};
    assign w_remSub   = w_remShift - {1'b0, r_divisor};

    assign done      = r_running && (r_count == c_LAST);
    assign product   = r_acc;
    assign quotient  = r_quot;
    assign remainder = r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_running <= 1'b0;
            r_isMul   <= 1'b0;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else if (start) begin
            r_running <= 1'b1;
            r_isMul   <= isMul;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= opA;
            r_mplier  <= opB;
            r_rem     <= '0;
            r_quot    <= opA;
            r_divisor <= opB;
        end else if (r_running) begin
            r_count <= r_count + c_CNT_W'(1);
            if (done) begin
                r_running <= 1'b0;
            end
            if (r_isMul) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end else begin
                // A borrow means the trial subtraction failed; keep the shifted value.
                r_rem  <= w_remSub[WIDTH] ? w_remShift[WIDTH-1:0] : w_remSub[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], ~w_remSub[WIDTH]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_sequencer
// Brief    : ALU execute-stage controller: handshake, flags, mul/div sequencing
// Revision : 1.0
// ============================================================================
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  aluctrl                ctrl,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output flg                    flags,
    output logic                  div_by_zero,
    output logic                  illegal_op,
    output logic                  busy
);

    localparam int c_SH_W = $clog2(DATA_WIDTH);

    alu_seq_state_e        r_state;
    alu_seq_state_e        w_stateNext;
    alu_op_e               w_op;
    md_op_e                w_mdOp;
    md_op_e                r_mdOp;
    logic                  w_accept;
    logic                  w_consume;
    logic                  w_isDivMod;
    logic                  w_divZero;
    logic                  w_isLong;
    logic                  w_scIllegal;
    logic                  w_coreDone;
    logic [c_SH_W-1:0]     w_shamt;
    logic [DATA_WIDTH-1:0] w_scResult;
    logic [DATA_WIDTH-1:0] w_product;
    logic [DATA_WIDTH-1:0] w_quotient;
    logic [DATA_WIDTH-1:0] w_remainder;
    logic [DATA_WIDTH-1:0] w_coreResult;
    flg                    w_cmpFlags;
    logic                  r_outValid;
    logic                  r_useCore;
    logic                  r_divByZero;
    logic                  r_illegalOp;
    logic [DATA_WIDTH-1:0] r_result;
    flg                    r_flags;

    assign in_ready  = (r_state == IDLE) && (!r_outValid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_outValid && out_ready;

    always_comb begin
        w_op          = decode_op(ctrl);
        w_shamt       = op_b[c_SH_W-1:0];
        w_divZero     = (op_b == '0);
        w_isDivMod    = (w_op == OP_DIV) || (w_op == OP_MOD);
        w_isLong      = (w_op == OP_MUL) || (w_isDivMod && !w_divZero);
        w_cmpFlags.GT = $signed(op_a) > $signed(op_b);
        w_cmpFlags.ET = (op_a == op_b);
        w_mdOp        = (w_op == OP_MUL) ? MD_MUL : ((w_op == OP_DIV) ? MD_DIV : MD_MOD);
        w_scIllegal   = 1'b0;
        w_scResult    = '0;
        case (w_op)
            OP_ADD:     w_scResult = op_a + op_b;
            OP_SUB:     w_scResult = op_a - op_b;
            // Div/Mod only land here as results when the divisor is zero.
            OP_DIV:     w_scResult = '1;
            OP_MOD:     w_scResult = op_a;
            OP_LSL:     w_scResult = op_a << w_shamt;
            OP_LSR:     w_scResult = op_a >> w_shamt;
            OP_ASR:     w_scResult = $unsigned($signed(op_a) >>> w_shamt);
            OP_OR:      w_scResult = op_a | op_b;
            OP_AND:     w_scResult = op_a & op_b;
            OP_NOT:     w_scResult = ~op_a;
            OP_MOV:     w_scResult = op_b;
            OP_ILLEGAL: w_scIllegal = 1'b1;
            default:    w_scResult = '0;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_isLong) w_stateNext = MULDIV;
            MULDIV:  if (w_coreDone)           w_stateNext = DONE;
            DONE:    if (w_consume)            w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_useCore   <= 1'b0;
            r_mdOp      <= MD_MUL;
            r_divByZero <= 1'b0;
            r_illegalOp <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            if (w_consume) begin
                r_outValid <= 1'b0;
            end
            if (w_coreDone) begin
                r_outValid <= 1'b1;
            end
            if (w_accept) begin
                r_useCore   <= w_isLong;
                r_mdOp      <= w_mdOp;
                r_divByZero <= w_isDivMod && w_divZero;
                r_illegalOp <= w_scIllegal;
                r_result    <= w_scResult;
                if (!w_isLong) begin
                    r_outValid <= 1'b1;
                end
                if (w_op == OP_CMP) begin
                    r_flags <= w_cmpFlags;
                end
            end
        end
    end

    alu_muldiv_iter #(
        .WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (w_accept && w_isLong),
        .isMul     (w_op == OP_MUL),
        .opA       (op_a),
        .opB       (op_b),
        .product   (w_product),
        .quotient  (w_quotient),
        .remainder (w_remainder),
        .done      (w_coreDone)
    );

    always_comb begin
        case (r_mdOp)
            MD_MUL:  w_coreResult = w_product;
            MD_DIV:  w_coreResult = w_quotient;
            default: w_coreResult = w_remainder;
        endcase
    end

    // Core registers hold their final value until the next start, which cannot
    // happen before this result is consumed.
    assign result      = r_useCore ? w_coreResult : r_result;
    assign out_valid   = r_outValid;
    assign flags       = r_flags;
    assign div_by_zero = r_divByZero;
    assign illegal_op  = r_illegalOp;
    assign busy        = (r_state == MULDIV);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_sequencer
// Brief    : Scoreboard bench for alu_exec_sequencer
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_alu_exec_sequencer;
    import alu_exec_sequencer_pkg::*;

    localparam logic [12:0] c_ADD = 13'h1000, c_SUB = 13'h0800, c_CMP = 13'h0400,
                            c_MUL = 13'h0200, c_DIV = 13'h0100, c_MOD = 13'h0080,
                            c_LSL = 13'h0040, c_LSR = 13'h0020, c_ASR = 13'h0010,
                            c_OR  = 13'h0008, c_AND = 13'h0004, c_NOT = 13'h0002,
                            c_MOV = 13'h0001;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        div_by_zero, illegal_op, busy;
    aluctrl      ctrl;
    logic [15:0] op_a, op_b, result;
    flg          flags;

    typedef struct {
        logic [15:0] res;
        logic        dbz;
        logic        ill;
        logic [1:0]  flg;
        int          lat;
    } exp_t;

    typedef struct {
        logic [15:0] res;
        logic        dbz;
        logic        ill;
        logic [1:0]  flg;
        int          lat;
        int          busyCnt;
        bit          rdySeen;
    } obs_t;

    exp_t       sb[$];
    logic [1:0] m_flags = 2'b00;
    int         errors  = 0;
    int         checks  = 0;

    always #5 clk = ~clk;

    alu_exec_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ctrl        (ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op),
        .busy        (busy)
    );

    // Reference model; the highest set ctrl bit (Add at bit 12) wins.
    function automatic exp_t model(input logic [12:0] c, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   top = -1;
        e.res = 16'h0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
        for (int i = 0; i < 13; i++) if (c[i]) top = i;
        case (top)
            12: e.res = a + b;
            11: e.res = a - b;
            10: m_flags = {$signed(a) > $signed(b), a == b};
            9:  begin e.res = 16'(32'(a) * 32'(b)); e.lat = 17; end
            8:  if (b == 16'h0) begin e.res = 16'hFFFF; e.dbz = 1'b1; end
                else begin e.res = a / b; e.lat = 17; end
            7:  if (b == 16'h0) begin e.res = a; e.dbz = 1'b1; end
                else begin e.res = a % b; e.lat = 17; end
            6:  e.res = a << b[3:0];
            5:  e.res = a >> b[3:0];
            4:  e.res = 16'($signed(a) >>> b[3:0]);
            3:  e.res = a | b;
            2:  e.res = a & b;
            1:  e.res = ~a;
            0:  e.res = b;
            default: e.ill = 1'b1;
        endcase
        e.flg = m_flags;
        return e;
    endfunction

    // Presents one op (call near a negedge), pushes its expectation at accept.
    task automatic issue(input logic [12:0] c, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        ctrl = aluctrl'(c); op_a = a; op_b = b; in_valid = 1'b1;
        while (!in_ready) begin
            n++;
            if (n > 50) begin
                $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", n);
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
        end
        @(posedge clk);
        sb.push_back(model(c, a, b));
        #1;
        in_valid = 1'b0;
        ctrl = aluctrl'(13'($urandom));
        op_a = 16'($urandom);
        op_b = 16'($urandom);
    endtask

    task automatic await_out(output obs_t o);
        o.lat = 0; o.busyCnt = 0; o.rdySeen = 1'b0;
        do begin
            @(negedge clk);
            o.lat++;
            if (busy) o.busyCnt++;
            if (in_ready) o.rdySeen = 1'b1;
        end while (!out_valid && o.lat < 60);
        if (!out_valid) begin
            $display("FAIL result_timeout: out_valid still 0 after %0d cycles, required 1", o.lat);
            $fatal(1, "result timeout");
        end
        o.res = result; o.dbz = div_by_zero; o.ill = illegal_op; o.flg = flags;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ctrl = aluctrl'(13'h0); op_a = 16'h0; op_b = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== 16'h0)      begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
        checks++; if (flags !== 2'b00)       begin errors++; $display("FAIL reset_flags got %b exp 00", flags); end
        checks++; if (div_by_zero !== 1'b0)  begin errors++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
        checks++; if (illegal_op !== 1'b0)   begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal_op); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single_cycle();
        logic [12:0] cs [12] = '{c_ADD, c_SUB, c_LSL, c_LSR, c_ASR, c_OR, c_AND, c_NOT,
                                 c_MOV, 13'h0000, c_ADD | c_MOV, c_SUB | c_MUL};
        logic [15:0] as [12] = '{16'h7FFF, 16'h0000, 16'h0001, 16'h8000, 16'h8000, 16'hF0F0,
                                 16'hF0F0, 16'h00FF, 16'hDEAD, 16'h1234, 16'h0010, 16'h0100};
        logic [15:0] bs [12] = '{16'h0001, 16'h0001, 16'h0013, 16'h000F, 16'h0004, 16'h0F0F,
                                 16'h3C3C, 16'h0000, 16'hBEEF, 16'h5678, 16'h0020, 16'h0001};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            issue(cs[i], as[i], bs[i]);
            await_out(o);
            e = sb.pop_front();
            checks++; if (o.res !== e.res) begin errors++; $display("FAIL single[%0d]_result got %h exp %h", i, o.res, e.res); end
            checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL single[%0d]_latency got %0d exp %0d", i, o.lat, e.lat); end
            checks++; if (o.ill !== e.ill) begin errors++; $display("FAIL single[%0d]_illegal got %b exp %b", i, o.ill, e.ill); end
            checks++; if (o.flg !== e.flg) begin errors++; $display("FAIL single[%0d]_flags got %b exp %b", i, o.flg, e.flg); end
        end
    endtask

    task automatic test_mul();
        logic [15:0] as [2] = '{16'd300, 16'hFFFF};
        logic [15:0] bs [2] = '{16'd300, 16'h0003};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(c_MUL, as[i], bs[i]);
            await_out(o);
            e = sb.pop_front();
            checks++; if (o.res !== e.res)   begin errors++; $display("FAIL mul[%0d]_result got %h exp %h", i, o.res, e.res); end
            checks++; if (o.lat !== 17)      begin errors++; $display("FAIL mul[%0d]_latency got %0d exp 17", i, o.lat); end
            checks++; if (o.busyCnt !== 16)  begin errors++; $display("FAIL mul[%0d]_busy_cycles got %0d exp 16", i, o.busyCnt); end
            checks++; if (o.rdySeen !== 1'b0) begin errors++; $display("FAIL mul[%0d]_in_ready_seen got %b exp 0", i, o.rdySeen); end
        end
    endtask

    task automatic test_div();
        logic [12:0] cs [6] = '{c_DIV, c_MOD, c_DIV, c_MOD, c_DIV, c_MOD};
        logic [15:0] as [6] = '{16'd100, 16'd100, 16'd5, 16'h1234, 16'hFFFF, 16'h8000};
        logic [15:0] bs [6] = '{16'd7, 16'd7, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(cs[i], as[i], bs[i]);
            await_out(o);
            e = sb.pop_front();
            checks++; if (o.res !== e.res) begin errors++; $display("FAIL divmod[%0d]_result got %h exp %h", i, o.res, e.res); end
            checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL divmod[%0d]_latency got %0d exp %0d", i, o.lat, e.lat); end
            checks++; if (o.dbz !== e.dbz) begin errors++; $display("FAIL divmod[%0d]_div_by_zero got %b exp %b", i, o.dbz, e.dbz); end
        end
    endtask

    task automatic test_cmp();
        logic [12:0] cs [4] = '{c_CMP, c_CMP, c_CMP, c_ADD};
        logic [15:0] as [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0001};
        logic [15:0] bs [4] = '{16'h0001, 16'h8000, 16'h0005, 16'h0002};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(cs[i], as[i], bs[i]);
            await_out(o);
            e = sb.pop_front();
            checks++; if (o.res !== e.res) begin errors++; $display("FAIL cmp[%0d]_result got %h exp %h", i, o.res, e.res); end
            checks++; if (o.flg !== e.flg) begin errors++; $display("FAIL cmp[%0d]_flags got %b exp %b", i, o.flg, e.flg); end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        issue(c_OR, 16'h1200, 16'h0034);
        out_ready = 1'b0;
        ctrl = aluctrl'(c_MOV); op_a = 16'h0000; op_b = 16'hBEEF; in_valid = 1'b1;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || result !== e.res) begin errors++; $display("FAIL hold[%0d]_result got v=%b %h exp v=1 %h", i, out_valid, result, e.res); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold[%0d]_in_ready got %b exp 0", i, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        @(posedge clk);
        if (in_ready) sb.push_back(model(c_MOV, 16'h0000, 16'hBEEF));
        #1 in_valid = 1'b0;
        @(negedge clk);
        e = (sb.size() > 0) ? sb.pop_front() : '{16'hBEEF, 1'b0, 1'b0, m_flags, 1};
        checks++; if (out_valid !== 1'b1 || result !== e.res) begin errors++; $display("FAIL release_result got v=%b %h exp v=1 %h", out_valid, result, e.res); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] cs [4] = '{c_ADD, c_SUB, c_NOT, c_MOV};
        logic [15:0] as [4] = '{16'h0001, 16'h000A, 16'h0000, 16'h0000};
        logic [15:0] bs [4] = '{16'h0001, 16'h0003, 16'h0000, 16'h55AA};
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctrl = aluctrl'(cs[i]); op_a = as[i]; op_b = bs[i]; in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d]_in_ready got %b exp 1", i, in_ready); end
            @(posedge clk);
            sb.push_back(model(cs[i], as[i], bs[i]));
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1 || result !== e.res) begin errors++; $display("FAIL b2b[%0d]_result got v=%b %h exp v=1 %h", i, out_valid, result, e.res); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        obs_t o;
        exp_t e;
        issue(c_DIV, 16'hFFFF, 16'h0003);
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL middiv_busy got %b exp 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        m_flags = 2'b00;
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b exp 0", out_valid); end
        checks++; if (flags !== 2'b00)    begin errors++; $display("FAIL abort_flags got %b exp 00", flags); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready got %b exp 1", in_ready); end
        issue(c_MOV, 16'h0000, 16'h1234);
        await_out(o);
        e = sb.pop_front();
        checks++; if (o.res !== e.res) begin errors++; $display("FAIL post_reset_mov_result got %h exp %h", o.res, e.res); end
        checks++; if (o.lat !== 1)     begin errors++; $display("FAIL post_reset_mov_latency got %0d exp 1", o.lat); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_cmp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
